// File: rtl/gb_cpu_common_pkg.sv
// Shared Game Boy CPU definitions: fetch FSM states, the CB prefix byte,
// immediate-length codes and the hard-lock opcode set.
package gb_cpu_common_pkg;

    // Fetch sequencer states; the shared names keep the decoder's encodings.
    typedef enum logic [2:0] {
        READ_OPCODE    = 3'd0,
        READ_CB_OPCODE = 3'd1,
        READ_R8        = 3'd2,
        READ_R16_BYTE0 = 3'd3,
        READ_R16_BYTE1 = 3'd4,
        ISSUE          = 3'd5,
        LOCKED         = 3'd6
    } fetch_state_t;

    // Prefix byte that selects the extended (bit/rotate/shift) opcode page.
    localparam logic [7:0] CB_PREFIX = 8'hCB;

    // Number of immediate bytes that follow an opcode.
    localparam logic [1:0] IMM_LEN_NONE = 2'd0;
    localparam logic [1:0] IMM_LEN_8    = 2'd1;
    localparam logic [1:0] IMM_LEN_16   = 2'd2;

    // Undefined opcodes that freeze the real CPU until reset.
    function automatic logic is_hardlock_opcode(input logic [7:0] opcode);
        case (opcode)
            8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB,
            8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/gb_cpu_imm_len.sv
// Opcode classifier: how many immediate bytes follow a non-prefixed opcode,
// and whether the opcode is one of the hard-lock opcodes. Shared with the decoder.
module gb_cpu_imm_len
    import gb_cpu_common_pkg::*;
(
    input  logic [7:0] opcode,
    output logic [1:0] imm_len,
    output logic       is_hardlock
);

    // Pure decode of the opcode into immediate length and lock flag.
    always_comb begin
        imm_len     = IMM_LEN_NONE;
        is_hardlock = is_hardlock_opcode(opcode);
        casez (opcode)
            8'b00???110, 8'b11???110,
            8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38,
            8'hE0, 8'hF0, 8'hE8, 8'hF8:
                imm_len = IMM_LEN_8;
            8'b00??0001,
            8'h08, 8'hC2, 8'hCA, 8'hD2, 8'hDA, 8'hC3, 8'hC4,
            8'hCC, 8'hD4, 8'hDC, 8'hCD, 8'hEA, 8'hFA:
                imm_len = IMM_LEN_16;
            default:
                imm_len = IMM_LEN_NONE;
        endcase
    end

endmodule

// File: rtl/gb_cpu_fetch.sv
// Game Boy CPU instruction fetch/sequencer. Reads instruction bytes one at a
// time, resolves the CB prefix and immediates, and hands a complete bundle to
// the decoder over a valid/ready handshake. Execute can redirect the PC at any time.
// Optional feature: define GB_CPU_FETCH_HARDLOCK_EN to freeze on hard-lock opcodes.
module gb_cpu_fetch
    import gb_cpu_common_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0100
) (
    input  logic         clk,
    input  logic         reset,
    output logic         mem_rd_req,
    output logic [15:0]  mem_addr,
    input  logic         mem_rd_ack,
    input  logic [7:0]   mem_rdata,
    input  logic         redirect_valid,
    input  logic [15:0]  redirect_pc,
    output logic         instr_valid,
    input  logic         instr_ready,
    output logic [7:0]   instr_opcode,
    output logic         instr_cb,
    output logic [15:0]  instr_imm,
    output logic [1:0]   instr_imm_len,
    output logic [15:0]  instr_pc,
    output logic [15:0]  pc,
    output fetch_state_t fetch_state
);

    fetch_state_t state;
    fetch_state_t state_next;
    logic [15:0]  pc_next;
    logic [15:0]  instr_pc_next;
    logic [7:0]   instr_opcode_next;
    logic         instr_cb_next;
    logic [15:0]  instr_imm_next;
    logic [1:0]   instr_imm_len_next;
    logic         fetching;
    logic         byte_taken;
    logic [1:0]   lookup_len;
    logic         lookup_hardlock;
    logic         lock_hit;

    gb_cpu_imm_len u_imm_len (
        .opcode      (mem_rdata),
        .imm_len     (lookup_len),
        .is_hardlock (lookup_hardlock)
    );

`ifdef GB_CPU_FETCH_HARDLOCK_EN
    assign lock_hit = lookup_hardlock;
`else
    logic unused_hardlock;
    assign unused_hardlock = lookup_hardlock;
    assign lock_hit        = 1'b0;
`endif

    // Memory is only requested in the byte-collecting states, never while in reset.
    assign fetching    = (state != ISSUE) && (state != LOCKED);
    assign mem_rd_req  = fetching && !reset;
    assign mem_addr    = pc;
    assign byte_taken  = mem_rd_req && mem_rd_ack;
    assign instr_valid = (state == ISSUE);
    assign fetch_state = state;

    // Next-state and bundle assembly; a redirect overrides any byte or handshake.
    always_comb begin
        state_next         = state;
        pc_next            = pc;
        instr_pc_next      = instr_pc;
        instr_opcode_next  = instr_opcode;
        instr_cb_next      = instr_cb;
        instr_imm_next     = instr_imm;
        instr_imm_len_next = instr_imm_len;

        if (redirect_valid && (state != LOCKED)) begin
            state_next         = READ_OPCODE;
            pc_next            = redirect_pc;
            instr_cb_next      = 1'b0;
            instr_imm_next     = 16'h0000;
            instr_imm_len_next = IMM_LEN_NONE;
        end else begin
            if (byte_taken) begin
                pc_next = pc + 16'd1;
            end
            case (state)
                READ_OPCODE: begin
                    if (byte_taken) begin
                        instr_pc_next     = pc;
                        instr_opcode_next = mem_rdata;
                        instr_cb_next     = 1'b0;
                        instr_imm_next    = 16'h0000;
                        if (mem_rdata == CB_PREFIX) begin
                            instr_imm_len_next = IMM_LEN_NONE;
                            state_next         = READ_CB_OPCODE;
                        end else if (lock_hit) begin
                            instr_imm_len_next = IMM_LEN_NONE;
                            state_next         = LOCKED;
                        end else begin
                            instr_imm_len_next = lookup_len;
                            case (lookup_len)
                                IMM_LEN_8:  state_next = READ_R8;
                                IMM_LEN_16: state_next = READ_R16_BYTE0;
                                default:    state_next = ISSUE;
                            endcase
                        end
                    end
                end
                READ_CB_OPCODE: begin
                    if (byte_taken) begin
                        instr_opcode_next = mem_rdata;
                        instr_cb_next     = 1'b1;
                        state_next        = ISSUE;
                    end
                end
                READ_R8: begin
                    if (byte_taken) begin
                        instr_imm_next = {8'h00, mem_rdata};
                        state_next     = ISSUE;
                    end
                end
                READ_R16_BYTE0: begin
                    if (byte_taken) begin
                        instr_imm_next = {8'h00, mem_rdata};
                        state_next     = READ_R16_BYTE1;
                    end
                end
                READ_R16_BYTE1: begin
                    if (byte_taken) begin
                        instr_imm_next = {mem_rdata, instr_imm[7:0]};
                        state_next     = ISSUE;
                    end
                end
                ISSUE: begin
                    if (instr_ready) begin
                        state_next     = READ_OPCODE;
                        instr_cb_next  = 1'b0;
                        instr_imm_next = 16'h0000;
                    end
                end
                LOCKED: begin
                    state_next = LOCKED;
                end
                default: begin
                    state_next = READ_OPCODE;
                end
            endcase
        end
    end

    // State, PC and bundle registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= READ_OPCODE;
            pc            <= RESET_PC;
            instr_pc      <= RESET_PC;
            instr_opcode  <= 8'h00;
            instr_cb      <= 1'b0;
            instr_imm     <= 16'h0000;
            instr_imm_len <= IMM_LEN_NONE;
        end else begin
            state         <= state_next;
            pc            <= pc_next;
            instr_pc      <= instr_pc_next;
            instr_opcode  <= instr_opcode_next;
            instr_cb      <= instr_cb_next;
            instr_imm     <= instr_imm_next;
            instr_imm_len <= instr_imm_len_next;
        end
    end

endmodule

// File: doc/gb_cpu_fetch.md
Name: gb_cpu_fetch

Overview:
- Instruction fetch/sequencer for the Game Boy CPU: the producer side of the opcode decode interface.
- Walks PC through memory byte by byte and detects the 0xCB prefix.
- Determines immediate length from the opcode and collects immediates.
- Presents one complete instruction bundle (opcode, CB flag, immediate, instruction PC) to the decoder/execute stage with a valid/ready handshake.
- Accepts PC redirects from execute (jumps, calls, returns, interrupts).

Parameters:
- RESET_PC, 16'h0100, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- mem_rd_req  output  1  byte read request to the memory bus.
- mem_addr  output  16  read address; stable while mem_rd_req is high.
- mem_rd_ack  input  1  read data valid this cycle; meaningful only while mem_rd_req is high.
- mem_rdata  input  8  read data.
- redirect_valid  input  1  load new PC and flush the in-flight fetch.
- redirect_pc  input  16  redirect target.
- instr_valid  output  1  instruction bundle valid.
- instr_ready  input  1  consumer accepts the bundle.
- instr_opcode  output  8  opcode, or the second byte when instr_cb=1.
- instr_cb  output  1  instruction was 0xCB-prefixed.
- instr_imm  output  16  immediate, little-endian assembled; imm8 in [7:0], [15:8]=0.
- instr_imm_len  output  2  immediate bytes: 0, 1 or 2.
- instr_pc  output  16  address of the first instruction byte.
- pc  output  16  address of the next byte to fetch.
- fetch_state  output  fetch_state_t  current FSM state, for decoder/debug.

Behaviour:
- Reset (async):
  - pc=RESET_PC; state=READ_OPCODE.
  - mem_rd_req=0 during reset; asserted from the first cycle after reset release.
  - instr_valid=0, instr_opcode=0, instr_cb=0, instr_imm=0, instr_imm_len=0, instr_pc=RESET_PC.
- Memory handshake:
  - In every fetch state, mem_rd_req=1 and mem_addr=pc.
  - A byte is consumed on the rising edge where mem_rd_req & mem_rd_ack; same-cycle ack is allowed (zero-wait).
  - Each consumed byte advances pc by 1, mod 2^16 (0xFFFF wraps to 0x0000).
- FSM states (fetch_state_t):
  - READ_OPCODE: on byte, instr_pc<=pc, opcode<=byte.
    - If byte==0xCB, go to READ_CB_OPCODE.
    - Else imm length L=lookup(byte): L=0 goes to ISSUE, L=1 to READ_R8, L=2 to READ_R16_BYTE0.
  - READ_CB_OPCODE: on byte, opcode<=byte, cb<=1, then ISSUE. CB opcodes never carry immediates.
  - READ_R8: on byte, imm[7:0]<=byte, then ISSUE.
  - READ_R16_BYTE0: on byte, imm[7:0]<=byte, then READ_R16_BYTE1.
  - READ_R16_BYTE1: on byte, imm[15:8]<=byte, then ISSUE.
  - ISSUE: mem_rd_req=0, instr_valid=1, all instr_* held stable. On instr_valid & instr_ready, go to READ_OPCODE with cb and imm cleared.
- Length lookup:
  - imm8 (L=1): 00_???110, 0x10 (STOP; second byte carried as imm8), 0x18, 0x20, 0x28, 0x30, 0x38, 11_???110, 0xE0, 0xF0, 0xE8, 0xF8.
  - imm16 (L=2): 00_??0001, 0x08, 0xC2, 0xCA, 0xD2, 0xDA, 0xC3, 0xC4, 0xCC, 0xD4, 0xDC, 0xCD, 0xEA, 0xFA.
  - All other opcodes: L=0.
- Latency with zero-wait memory:
  - 1-byte instruction: valid on the 2nd cycle after the opcode request (fetch cycle, then ISSUE).
  - Each extra byte adds 1 cycle.
  - Back-to-back throughput is one instruction per (bytes+1) cycles.
- Redirect:
  - Has priority over everything, in any state.
  - Next edge: pc<=redirect_pc, state<=READ_OPCODE, instr_valid<=0, partial bundle discarded.
  - An ack in the redirect cycle is ignored and pc is not incremented.
  - Redirect coinciding with an instr_ready handshake: the handshake completes (bundle consumed) and the redirect is still applied.
- Stall: instr_ready low holds ISSUE indefinitely; no memory requests issued.

Optional Feature:
- Macro: GB_CPU_FETCH_HARDLOCK_EN.
- Defined:
  - An opcode in {D3,DB,DD,E3,E4,EB,EC,ED,F4,FC,FD} in READ_OPCODE moves the FSM to LOCKED.
  - LOCKED: mem_rd_req=0, instr_valid=0. Exit only via reset; redirect is ignored.
  - fetch_state reports LOCKED.
- Undefined: these opcodes are treated as L=0 and issued normally; LOCKED is unreachable.

Decomposition:
- gb_cpu_common_pkg:
  - fetch_state_t (READ_OPCODE, READ_CB_OPCODE, READ_R8, READ_R16_BYTE0, READ_R16_BYTE1, ISSUE, LOCKED), keeping the existing decoder_state_t encodings for the shared names.
  - Constant CB_PREFIX=8'hCB.
  - Function/constant for the hard-lock opcode set.
- Sub-module gb_cpu_imm_len: combinational opcode to {imm_len[1:0], is_hardlock}, reused by the decoder.

Test Plan:
- ack tied high, memory 0x0100={00,3E,42,C3,34,12}, ready=1:
  - NOP issued with pc=0x0100, imm_len=0.
  - LD A,0x42 issued with imm=0x0042, len=1, instr_pc=0x0101.
  - JP 0x1234 issued with imm=0x1234, len=2, instr_pc=0x0103.
  - Issue cycles spaced 2, 3 and 4 cycles apart.
- Bytes {CB,37}: instr_cb=1, opcode=0x37, len=0, pc advances by 2.
- ack low 3 cycles per byte on 0x01 0xCD 0xAB: mem_addr stable while waiting; imm=0xABCD; no byte skipped or duplicated.
- ready held low 5 cycles in ISSUE: bundle stable, mem_rd_req=0, pc unchanged; proceeds after ready=1.
- redirect_pc=0x0038 asserted in READ_R16_BYTE0 with ack=1: partial bundle dropped; next fetch address 0x0038; no valid asserted for the dropped instruction.
- pc=0xFFFF fetching 0x3E,0x11: imm byte read from 0x0000; pc=0x0001 afterward.
- With GB_CPU_FETCH_HARDLOCK_EN, opcode 0xD3: LOCKED entered; no further requests; redirect ignored; async reset returns to READ_OPCODE at RESET_PC.
